// File: rtl/seg_skew_stage_if.sv
// ---------------------------------------------------------------------------
// seg_skew_stage_if
//
// Purpose: bundles the control, data and status signals of seg_skew_stage.
// The clock and reset stay plain ports on the module.
//
// Signals (named from the point of view of the stage):
//   i_en        clock enable / stall; when low, all stage state holds
//   i_flush     synchronous pipeline clear
//   i_mode      0 = skew, 1 = deskew; only captured while the pipeline is empty
//   i_valid     i_data carries a word this cycle
//   i_data      packed word, segment k at bits [k*W +: W]
//   o_data      packed delayed segments
//   o_seg_valid bit k high when segment k of o_data is valid
//   o_mode      mode currently applied
//   o_busy      any stage holds a valid segment
//
// Modports:
//   master  the producer/consumer side that drives i_* and observes o_*
//   slave   the stage itself
// ---------------------------------------------------------------------------
interface seg_skew_stage_if #(
    parameter int P_SEG_WIDTH = 6,
    parameter int P_SEG_NUM   = 4
);
    logic                               i_en;
    logic                               i_flush;
    logic                               i_mode;
    logic                               i_valid;
    logic [P_SEG_NUM*P_SEG_WIDTH-1:0]   i_data;
    logic [P_SEG_NUM*P_SEG_WIDTH-1:0]   o_data;
    logic [P_SEG_NUM-1:0]               o_seg_valid;
    logic                               o_mode;
    logic                               o_busy;

    modport master (
        output i_en,
        output i_flush,
        output i_mode,
        output i_valid,
        output i_data,
        input  o_data,
        input  o_seg_valid,
        input  o_mode,
        input  o_busy
    );

    modport slave (
        input  i_en,
        input  i_flush,
        input  i_mode,
        input  i_valid,
        input  i_data,
        output o_data,
        output o_seg_valid,
        output o_mode,
        output o_busy
    );
endinterface

// File: rtl/seg_skew_stage.sv
// ---------------------------------------------------------------------------
// seg_skew_stage
//
// Purpose: splits a packed word into P_SEG_NUM segments of P_SEG_WIDTH bits
// and delays each segment by a segment-dependent number of enabled cycles.
//   mode 0 (skew):   segment k latency = 1 + k*P_SKEW_STEP
//   mode 1 (deskew): segment k latency = 1 + (P_SEG_NUM-1-k)*P_SKEW_STEP
// A mode-0 instance feeding a mode-1 instance re-aligns every segment.
//
// Every segment owns a D-stage shift register (data + valid), with
// D = 1 + (P_SEG_NUM-1)*P_SKEW_STEP. The output for segment k is simply a
// tap on that register chosen by the applied mode, so outputs are purely
// registered.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset (clears data, valid bits and mode)
//   bus      seg_skew_stage_if.slave: i_en, i_flush, i_mode, i_valid, i_data
//            in; o_data, o_seg_valid, o_mode, o_busy out
//
// Edge priority: reset > flush > enable.
// ---------------------------------------------------------------------------
module seg_skew_stage #(
    parameter int P_SEG_WIDTH = 6,
    parameter int P_SEG_NUM   = 4,
    parameter int P_SKEW_STEP = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    seg_skew_stage_if.slave bus
);
    localparam int W = P_SEG_WIDTH;
    localparam int N = P_SEG_NUM;
    localparam int D = 1 + (N - 1) * P_SKEW_STEP;

    logic           r_mode;
    logic           busy;
    logic [N-1:0]   seg_busy;

    // Mode register: a new mode is only taken while nothing is in flight, so
    // a word never changes its delay profile half-way through the pipeline.
    // The word accepted on the capture edge already travels under the new
    // mode because the taps follow r_mode from that edge on.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mode <= 1'b0;
        end else if (bus.i_flush) begin
            r_mode <= r_mode;
        end else if (bus.i_en && !busy) begin
            r_mode <= bus.i_mode;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_seg
        // Stage indices (0-based) of the output tap in each mode.
        localparam int TAP_SKEW   = k * P_SKEW_STEP;
        localparam int TAP_DESKEW = (N - 1 - k) * P_SKEW_STEP;

        logic [W-1:0]   data_p [D];
        logic           vld_p  [D];
        logic           any_vld;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                for (int s = 0; s < D; s++) begin
                    data_p[s] <= '0;
                    vld_p[s]  <= 1'b0;
                end
            end else if (bus.i_flush) begin
                for (int s = 0; s < D; s++) begin
                    data_p[s] <= '0;
                    vld_p[s]  <= 1'b0;
                end
            end else if (bus.i_en) begin
                // stage 1: load this word's segment
                data_p[0] <= bus.i_data[k*W +: W];
                vld_p[0]  <= bus.i_valid;
                // stages 2..D: shift; data moves even when its valid is low
                for (int s = 1; s < D; s++) begin
                    data_p[s] <= data_p[s-1];
                    vld_p[s]  <= vld_p[s-1];
                end
            end
        end

        // Busy must see every stage, not just the tap: a segment keeps
        // occupying the chain until it falls off stage D.
        always_comb begin
            any_vld = 1'b0;
            for (int s = 0; s < D; s++) begin
                any_vld = any_vld | vld_p[s];
            end
        end

        assign seg_busy[k] = any_vld;

        assign bus.o_data[k*W +: W] = r_mode ? data_p[TAP_DESKEW] : data_p[TAP_SKEW];
        assign bus.o_seg_valid[k]   = r_mode ? vld_p[TAP_DESKEW]  : vld_p[TAP_SKEW];
    end

    assign busy       = |seg_busy;
    assign bus.o_busy = busy;
    assign bus.o_mode = r_mode;

endmodule

// File: tb/tb_seg_skew_stage.sv
// ---------------------------------------------------------------------------
// tb_seg_skew_stage
//
// Bench for seg_skew_stage. Instance A (W=6, N=4, S=1) carries most tests;
// instance B (mode 1) is chained after A to check re-alignment; instance C
// (W=8, N=3, S=2) checks the wider-step latencies.
// ---------------------------------------------------------------------------
module tb_seg_skew_stage;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    seg_skew_stage_if #(.P_SEG_WIDTH(6), .P_SEG_NUM(4)) a_if ();
    seg_skew_stage_if #(.P_SEG_WIDTH(6), .P_SEG_NUM(4)) b_if ();
    seg_skew_stage_if #(.P_SEG_WIDTH(8), .P_SEG_NUM(3)) c_if ();

    seg_skew_stage #(.P_SEG_WIDTH(6), .P_SEG_NUM(4), .P_SKEW_STEP(1)) u_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (a_if.slave)
    );

    seg_skew_stage #(.P_SEG_WIDTH(6), .P_SEG_NUM(4), .P_SKEW_STEP(1)) u_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (b_if.slave)
    );

    seg_skew_stage #(.P_SEG_WIDTH(8), .P_SEG_NUM(3), .P_SKEW_STEP(2)) u_c (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (c_if.slave)
    );

    // B re-aligns whatever A produces.
    assign b_if.i_en    = 1'b1;
    assign b_if.i_flush = 1'b0;
    assign b_if.i_mode  = 1'b1;
    assign b_if.i_data  = a_if.o_data;
    assign b_if.i_valid = |a_if.o_seg_valid;

    localparam logic [3:0][2:0] LAT0 = {3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [3:0][2:0] LAT1 = {3'd1, 3'd2, 3'd3, 3'd4};

    typedef struct packed {
        logic            mode;
        logic [23:0]     data;
        logic [3:0][5:0] seg;
        logic [3:0][2:0] lat;
    } vec_t;

    typedef struct {
        int unsigned due;
        int          seg;
        logic [5:0]  val;
    } sb_t;

    typedef struct {
        int unsigned cyc;
        logic [23:0] data;
    } cw_t;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int unsigned cyc_cnt  = 0;
    int unsigned en_cnt   = 0;
    int unsigned seen_cnt = 0;
    bit          chain_on = 1'b0;
    sb_t         sbq[$];
    cw_t         cq[$];
    vec_t        vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Queue one expected segment per lane, due after lat[k] enabled edges.
    task automatic push_exp(input logic [3:0][5:0] seg, input logic [3:0][2:0] lat);
        for (int k = 0; k < 4; k++) begin
            sbq.push_back('{due: en_cnt + lat[k], seg: k, val: seg[k]});
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (a_if.o_busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk(name, a_if.o_busy, 0);
    endtask

    // Edge bookkeeping for instance A.
    always @(posedge clk) begin
        cyc_cnt++;
        if (!rst_n || a_if.i_flush) sbq.delete();
        else if (a_if.i_en) en_cnt++;
    end

    // Scoreboard for A: after each enabled edge, every valid lane must match
    // the oldest pending entry for that lane and be due exactly now.
    always @(negedge clk) begin : mon_a
        bit            found;
        int            idx;
        int            nmiss;
        logic [23:0]   sh;
        if (en_cnt != seen_cnt) begin
            seen_cnt = en_cnt;
            for (int k = 0; k < 4; k++) begin
                if (a_if.o_seg_valid[k]) begin
                    found = 1'b0;
                    idx   = 0;
                    for (int i = 0; i < sbq.size(); i++) begin
                        if (!found && sbq[i].seg == k) begin
                            found = 1'b1;
                            idx   = i;
                        end
                    end
                    chk($sformatf("a_seg%0d_expected", k), found, 1);
                    if (found) begin
                        sh = a_if.o_data >> (6 * k);
                        chk($sformatf("a_seg%0d_value", k), sh[5:0], sbq[idx].val);
                        chk($sformatf("a_seg%0d_time", k), en_cnt, sbq[idx].due);
                        sbq.delete(idx);
                    end
                end
            end
            nmiss = 0;
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].due <= en_cnt) begin
                    nmiss++;
                    sbq.delete(i);
                end
            end
            chk("a_seg_missing", nmiss, 0);
        end
    end

    // Chain check: an all-valid word from B must be the next word pushed,
    // five cycles after it entered A.
    always @(negedge clk) begin : mon_chain
        cw_t w;
        if (chain_on && b_if.o_seg_valid == 4'hF) begin
            chk("chain_word_expected", cq.size() != 0, 1);
            if (cq.size() != 0) begin
                w = cq.pop_front();
                chk("chain_data", b_if.o_data, w.data);
                chk("chain_time", cyc_cnt, w.cyc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] snap_d;
        logic [3:0]  snap_v;
        logic [23:0] d;
        logic [2:0]  exp_mask;
        logic [23:0] sh;
        logic [7:0]  cexp [3];
        int          n;

        vecs[0] = '{1'b0, 24'hFEA541, {6'h3F, 6'h2A, 6'h15, 6'h01}, LAT0};
        vecs[1] = '{1'b1, 24'hFEA541, {6'h3F, 6'h2A, 6'h15, 6'h01}, LAT1};
        vecs[2] = '{1'b1, 24'h000FFF, {6'h00, 6'h00, 6'h3F, 6'h3F}, LAT1};
        vecs[3] = '{1'b0, 24'h555555, {6'h15, 6'h15, 6'h15, 6'h15}, LAT0};
        cexp[0] = 8'hC3;
        cexp[1] = 8'hB2;
        cexp[2] = 8'hA1;

        rst_n        = 1'b0;
        a_if.i_en    = 1'b1;
        a_if.i_flush = 1'b0;
        a_if.i_mode  = 1'b0;
        a_if.i_valid = 1'b0;
        a_if.i_data  = '0;
        c_if.i_en    = 1'b1;
        c_if.i_flush = 1'b0;
        c_if.i_mode  = 1'b0;
        c_if.i_valid = 1'b0;
        c_if.i_data  = '0;

        repeat (2) @(negedge clk);
        chk("rst_data",  a_if.o_data, 0);
        chk("rst_valid", a_if.o_seg_valid, 0);
        chk("rst_mode",  a_if.o_mode, 0);
        chk("rst_busy",  a_if.o_busy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single words in each mode, from an idle pipeline.
        for (int i = 0; i < 4; i++) begin
            wait_idle($sformatf("vec%0d_pre_idle", i));
            a_if.i_mode  = vecs[i].mode;
            a_if.i_valid = 1'b1;
            a_if.i_data  = vecs[i].data;
            push_exp(vecs[i].seg, vecs[i].lat);
            @(negedge clk);
            a_if.i_valid = 1'b0;
            chk($sformatf("vec%0d_mode", i), a_if.o_mode, vecs[i].mode);
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_busy_t3", i), a_if.o_busy, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_busy_t4", i), a_if.o_busy, 0);
        end

        // Stall with words in flight; i_valid during the stall is ignored.
        wait_idle("stall_pre_idle");
        for (int i = 0; i < 3; i++) begin
            d = 24'h3C0F00 + 24'h041041 * i;
            a_if.i_valid = 1'b1;
            a_if.i_data  = d;
            push_exp(d, LAT0);
            @(negedge clk);
        end
        a_if.i_valid = 1'b0;
        @(negedge clk);
        a_if.i_en    = 1'b0;
        a_if.i_valid = 1'b1;
        a_if.i_data  = 24'hFFFFFF;
        snap_d = a_if.o_data;
        snap_v = a_if.o_seg_valid;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_data", i),  a_if.o_data, snap_d);
            chk($sformatf("stall%0d_valid", i), a_if.o_seg_valid, snap_v);
            chk($sformatf("stall%0d_busy", i),  a_if.o_busy, 1);
        end
        a_if.i_en    = 1'b1;
        a_if.i_valid = 1'b0;
        wait_idle("stall_drain");

        // Mode change requested while busy waits for the pipeline to drain.
        a_if.i_valid = 1'b1;
        a_if.i_data  = 24'h2468AC;
        push_exp(24'h2468AC, LAT0);
        @(negedge clk);
        a_if.i_valid = 1'b0;
        a_if.i_mode  = 1'b1;
        n = 0;
        while (a_if.o_busy && n < 20) begin
            chk("defer_mode_hold", a_if.o_mode, 0);
            @(negedge clk);
            n++;
        end
        chk("defer_busy_fell",    a_if.o_busy, 0);
        chk("defer_mode_at_idle", a_if.o_mode, 0);
        @(negedge clk);
        chk("defer_mode_applied", a_if.o_mode, 1);
        a_if.i_mode = 1'b0;
        @(negedge clk);
        chk("defer_mode_back", a_if.o_mode, 0);

        // Chained skew -> deskew, eight back-to-back words.
        repeat (6) @(negedge clk);
        chain_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 24'h123456 + i;
            a_if.i_valid = 1'b1;
            a_if.i_data  = d;
            push_exp(d, LAT0);
            cq.push_back('{cyc: cyc_cnt + 5, data: d});
            @(negedge clk);
        end
        a_if.i_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("chain_all_words", cq.size(), 0);
        chain_on = 1'b0;

        // Flush two cycles after a word; the flush-cycle word is dropped.
        wait_idle("flush_pre_idle");
        a_if.i_valid = 1'b1;
        a_if.i_data  = 24'h0F0F0F;
        push_exp(24'h0F0F0F, LAT0);
        @(negedge clk);
        a_if.i_valid = 1'b0;
        @(negedge clk);
        a_if.i_flush = 1'b1;
        a_if.i_valid = 1'b1;
        a_if.i_data  = 24'h3F3F3F;
        @(negedge clk);
        a_if.i_flush = 1'b0;
        a_if.i_valid = 1'b0;
        chk("flush_valid", a_if.o_seg_valid, 0);
        chk("flush_busy",  a_if.o_busy, 0);
        repeat (8) @(negedge clk);
        chk("flush_no_residue", sbq.size(), 0);

        // Reset mid-flight in mode 1.
        a_if.i_mode  = 1'b1;
        a_if.i_valid = 1'b1;
        a_if.i_data  = 24'hABCDEF;
        push_exp(24'hABCDEF, LAT1);
        @(negedge clk);
        a_if.i_valid = 1'b0;
        chk("mreset_mode_before", a_if.o_mode, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mreset_data",  a_if.o_data, 0);
        chk("mreset_valid", a_if.o_seg_valid, 0);
        chk("mreset_mode",  a_if.o_mode, 0);
        chk("mreset_busy",  a_if.o_busy, 0);
        rst_n       = 1'b1;
        a_if.i_mode = 1'b0;
        repeat (6) @(negedge clk);
        chk("mreset_no_residue", sbq.size(), 0);

        // N=3, W=8, S=2: latencies 1, 3, 5 in mode 0.
        c_if.i_valid = 1'b1;
        c_if.i_data  = 24'hA1B2C3;
        @(negedge clk);
        c_if.i_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            exp_mask = (c == 1) ? 3'b001 : (c == 3) ? 3'b010 : (c == 5) ? 3'b100 : 3'b000;
            chk($sformatf("c_valid_cyc%0d", c), c_if.o_seg_valid, exp_mask);
            if (exp_mask != 3'b000) begin
                sh = c_if.o_data >> (8 * ((c - 1) / 2));
                chk($sformatf("c_data_cyc%0d", c), sh[7:0], cexp[(c - 1) / 2]);
            end
            @(negedge clk);
        end
        chk("c_busy_drained", c_if.o_busy, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/seg_skew_stage.md
# seg_skew_stage

Parametrised, handshake-aware successor of the modulator input skew stage. It splits a packed input word into `P_SEG_NUM` segments of `P_SEG_WIDTH` bits and delays each segment by a per-segment number of cycles, so that cascaded lower-order stages see their operand segments at staggered times. Mode 0 (skew) delays higher segments longer. Mode 1 (deskew) applies the mirror delay, which re-aligns a previously skewed word. The block sits between the input formatter and the cascaded accumulator stages, or after them as the output re-aligner.

## Interface
Parameters:
- `P_SEG_WIDTH`, default 6: bits per segment.
- `P_SEG_NUM`, default 4: number of segments; must be ≥ 2. Segment 0 is the LSB segment.
- `P_SKEW_STEP`, default 1: extra delay per segment index; must be ≥ 0.

Ports (clock and reset first):
- `i_clk` input 1: single clock; all state updates on the rising edge.
- `i_rst_n` input 1: reset; synchronous, active-low.
- `i_en` input 1: clock enable / stall; when low, all state holds.
- `i_flush` input 1: synchronous pipeline clear.
- `i_mode` input 1: 0 = skew, 1 = deskew; captured only when the pipeline is empty.
- `i_valid` input 1: `i_data` carries a word this cycle.
- `i_data` input P_SEG_NUM*P_SEG_WIDTH: packed word; segment k occupies bits [k*W +: W].
- `o_data` output P_SEG_NUM*P_SEG_WIDTH: packed delayed segments.
- `o_seg_valid` output P_SEG_NUM: bit k is high when segment k of `o_data` carries a valid segment.
- `o_mode` output 1: currently applied mode (`r_mode`).
- `o_busy` output 1: high when any pipeline stage holds a valid segment.

## Operation
- D = 1 + (P_SEG_NUM-1)*P_SKEW_STEP is the pipeline depth.
- Each segment has a D-stage shift register carrying data and a valid bit. Stage 1 loads `i_data` segment k and `i_valid`.
- Latency of segment k:
  - mode 0: L0(k) = 1 + k*P_SKEW_STEP.
  - mode 1: L1(k) = 1 + (P_SEG_NUM-1-k)*P_SKEW_STEP.
  - The output tap for segment k is stage L(k). All outputs are registered; there is no combinational path from input to output.
- A skew stage in mode 0 feeding a second instance in mode 1 gives every segment the same total latency, 2 + (P_SEG_NUM-1)*P_SKEW_STEP. The output segments are then aligned.
- Mode capture: on an enabled edge where no stage valid bit is set (`o_busy` = 0), `r_mode` ← `i_mode`. Otherwise `r_mode` holds. A word accepted on the capture cycle travels under the newly captured mode. A mode change requested while busy is deferred until the pipeline drains.
- Priority per edge: reset > flush > enable.
  - Reset: all data, valid bits and `r_mode` are cleared to 0.
  - Flush (`i_flush`=1, regardless of `i_en`): all data and valid bits are cleared. `i_valid` on that cycle is dropped. `r_mode` is unchanged.
  - `i_en`=0: every register holds, including outputs and `r_mode`. `i_valid` is ignored.
  - `i_en`=1: all stages shift by one.
- When a stage's valid bit is 0, its data register still shifts but its content is don't-care. Verification checks data only where `o_seg_valid[k]`=1.
- `o_busy` = OR of the valid bits of all stages 1..D. It is registered-derived, not input-derived.
- P_SKEW_STEP = 0: every segment has latency 1 and the modes are identical.

## Timing
- Reset values: `o_data` = 0, `o_seg_valid` = 0, `o_mode` = 0, `o_busy` = 0.
- Throughput is one word per enabled cycle; back-to-back words need no gap.
- A word accepted at edge t presents segment k at the output after edge t + L(k) − 1 + stalls, i.e. in the cycle following the L(k)-th enabled edge. Disabled cycles extend latency one-for-one.
- After `i_valid` falls, the pipeline needs D enabled edges to drain. `o_busy` falls after the last valid segment leaves stage D.
- Reset or flush in mid-operation loses all in-flight segments. The first output after the event is a word accepted on or after the next edge.

## Test plan
Defaults W=6, N=4, S=1 (D=4) unless noted.
1. Mode 0, single word: `i_data`=0xFEA541 (segs 0x01, 0x15, 0x2A, 0x3F) valid for one cycle at edge t → seg0=0x01 valid after t, seg1=0x15 after t+1, seg2=0x2A after t+2, seg3=0x3F after t+3. Each `o_seg_valid` bit pulses for exactly one cycle. `o_busy` is low after t+4.
2. Mode 1 with a mode change: with the pipeline idle, set `i_mode`=1 and send the same word at t → `o_mode`=1 after t; seg3 appears after t, seg2 after t+1, seg1 after t+2, seg0 after t+3.
3. Chained pair (mode 0 into mode 1), 8 back-to-back incrementing words → every output word has all 4 `o_seg_valid` bits high at the same time, 5 cycles after input, with values unchanged and in order.
4. Stall: drop `i_en` for 3 cycles while words are in flight → outputs freeze during the stall, latencies stretch by exactly 3, and no segment is lost or duplicated.
5. Flush and reset: assert `i_flush` 2 cycles after a word is sent (with `i_valid`=1 on the flush cycle) → `o_seg_valid`=0 and `o_busy`=0 after that edge, and the word on the flush cycle never appears. Repeat with `i_rst_n`=0 → all outputs 0 and `o_mode`=0.
6. Deferred mode: toggle `i_mode` while busy → `o_mode` is unchanged until the edge after `o_busy` falls. Also run with N=3, W=8, S=2: latencies are 1, 3, 5 in mode 0.
